datapath: RTL and testbench

32-bit bus-based CPU datapath: a single shared bus, a register subset (R2, R4, R5), PC, IR, MAR, MDR, Y, 64-bit Z, HI, LO, a constant register C and an ALU. It sits beneath the control unit, which drives every `*out`, `*in` and ALU-select signal directly, one micro-step per clock.

---
 rtl/datapath_pkg.sv | 20 ++
 rtl/datapath_alu.sv | 64 ++++++
 rtl/datapath.sv | 105 ++++++++++
 tb/tb_datapath.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared constants for the bus datapath: data width and ALU opcode encodings.
package datapath_pkg;

    localparam int DATA_W = 32;

    localparam logic [4:0] ALU_ADD  = 5'b00011;
    localparam logic [4:0] ALU_SUB  = 5'b00100;
    localparam logic [4:0] ALU_SHR  = 5'b00101;
    localparam logic [4:0] ALU_SHRA = 5'b00110;
    localparam logic [4:0] ALU_SHL  = 5'b00111;
    localparam logic [4:0] ALU_ROR  = 5'b01000;
    localparam logic [4:0] ALU_AND  = 5'b01001;
    localparam logic [4:0] ALU_OR   = 5'b01010;
    localparam logic [4:0] ALU_ROL  = 5'b01011;
    localparam logic [4:0] ALU_MUL  = 5'b01111;
    localparam logic [4:0] ALU_DIV  = 5'b10000;
    localparam logic [4:0] ALU_NEG  = 5'b10001;
    localparam logic [4:0] ALU_NOT  = 5'b10010;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A comes from Y, B from the bus; 64-bit result feeds Z.
module alu
    import datapath_pkg::*;
(
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    input  logic [4:0]          i_op,
    input  logic                i_inc_pc,
    input  logic                i_branch_flag,
    input  logic [DATA_W-1:0]   i_c,
    output logic [2*DATA_W-1:0] o_result
);

    logic [4:0]            w_sh;
    logic [2*DATA_W-1:0]   w_dbl_r;
    logic [2*DATA_W-1:0]   w_dbl_l;
    logic signed [63:0]    w_prod;
    logic signed [31:0]    w_sa;
    logic signed [31:0]    w_sb;
    logic [DATA_W-1:0]     w_quo;
    logic [DATA_W-1:0]     w_rem;

    assign w_sh    = i_b[4:0];
    assign w_sa    = $signed(i_a);
    assign w_sb    = $signed(i_b);
    // Rotates are done by shifting a doubled copy of A and picking one half.
    assign w_dbl_r = {i_a, i_a} >> w_sh;
    assign w_dbl_l = {i_a, i_a} << w_sh;
    assign w_prod  = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});

    always_comb begin
        w_quo = '0;
        w_rem = '0;
        if (i_b != '0) begin
            w_quo = w_sa / w_sb;
            w_rem = w_sa % w_sb;
        end
    end

    always_comb begin
        o_result = '0;
        if (i_inc_pc) begin
            o_result[31:0] = i_branch_flag ? (i_b + i_c) : (i_b + 32'd1);
        end else begin
            case (i_op)
                ALU_ADD:  o_result[31:0] = i_a + i_b;
                ALU_SUB:  o_result[31:0] = i_a - i_b;
                ALU_SHR:  o_result[31:0] = i_a >> w_sh;
                ALU_SHRA: o_result[31:0] = w_sa >>> w_sh;
                ALU_SHL:  o_result[31:0] = i_a << w_sh;
                ALU_ROR:  o_result[31:0] = w_dbl_r[31:0];
                ALU_AND:  o_result[31:0] = i_a & i_b;
                ALU_OR:   o_result[31:0] = i_a | i_b;
                ALU_ROL:  o_result[31:0] = w_dbl_l[63:32];
                ALU_MUL:  o_result       = w_prod;
                ALU_DIV:  o_result       = {w_rem, w_quo};
                ALU_NEG:  o_result[31:0] = -i_b;
                ALU_NOT:  o_result[31:0] = ~i_b;
                default:  o_result       = '0;
            endcase
        end
    end

endmodule

// File: rtl/datapath.sv
// Single-bus CPU datapath: priority bus mux, register file subset, Z/HI/LO and ALU.
module datapath
    import datapath_pkg::*;
(
    input  logic              Clock,
    input  logic              Clear,
    input  logic              PCout,
    input  logic              ZHighout,
    input  logic              Zlowout,
    input  logic              HIout,
    input  logic              LOout,
    input  logic              InPortout,
    input  logic              Cout,
    input  logic              MDRout,
    input  logic              R2out,
    input  logic              R4out,
    input  logic              MARin,
    input  logic              PCin,
    input  logic              MDRin,
    input  logic              IRin,
    input  logic              Yin,
    input  logic              IncPC,
    input  logic              Read,
    input  logic [4:0]        AND,
    input  logic              R5in,
    input  logic              R2in,
    input  logic              R4in,
    input  logic [DATA_W-1:0] Mdatain,
    input  logic              HIin,
    input  logic              LOin,
    input  logic              ZHighIn,
    input  logic              ZLowIn,
    input  logic              Cin,
    input  logic              branch_flag,
    output logic [DATA_W-1:0] BusMuxOut
);

    logic [DATA_W-1:0]   r_pc, r_ir, r_mar, r_mdr, r_y, r_hi, r_lo, r_c, r_inport;
    logic [DATA_W-1:0]   r_r2, r_r4, r_r5;
    logic [2*DATA_W-1:0] r_z;
    logic [DATA_W-1:0]   w_bus;
    logic [2*DATA_W-1:0] w_alu_res;

    // Highest-priority source wins when several outs are asserted together.
    always_comb begin
        w_bus = '0;
        if      (PCout)     w_bus = r_pc;
        else if (Zlowout)   w_bus = r_z[31:0];
        else if (ZHighout)  w_bus = r_z[63:32];
        else if (HIout)     w_bus = r_hi;
        else if (LOout)     w_bus = r_lo;
        else if (InPortout) w_bus = r_inport;
        else if (Cout)      w_bus = r_c;
        else if (MDRout)    w_bus = r_mdr;
        else if (R2out)     w_bus = r_r2;
        else if (R4out)     w_bus = r_r4;
    end

    assign BusMuxOut = w_bus;

    alu u_alu (
        .i_a           (r_y),
        .i_b           (w_bus),
        .i_op          (AND),
        .i_inc_pc      (IncPC),
        .i_branch_flag (branch_flag),
        .i_c           (r_c),
        .o_result      (w_alu_res)
    );

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r_pc     <= '0;
            r_ir     <= '0;
            r_mar    <= '0;
            r_mdr    <= '0;
            r_y      <= '0;
            r_z      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_c      <= '0;
            r_inport <= '0;
            r_r2     <= '0;
            r_r4     <= '0;
            r_r5     <= '0;
        end else begin
            if (PCin)    r_pc  <= w_bus;
            if (IRin)    r_ir  <= w_bus;
            if (MARin)   r_mar <= w_bus;
            if (MDRin)   r_mdr <= Read ? Mdatain : w_bus;
            if (Yin)     r_y   <= w_bus;
            if (HIin)    r_hi  <= w_bus;
            if (LOin)    r_lo  <= w_bus;
            if (R2in)    r_r2  <= w_bus;
            if (R4in)    r_r4  <= w_bus;
            if (R5in)    r_r5  <= w_bus;
            // C holds the sign-extended 19-bit immediate field of IR.
            if (Cin)     r_c   <= {{13{r_ir[18]}}, r_ir[18:0]};
            if (ZLowIn)  r_z[31:0]  <= w_alu_res[31:0];
            if (ZHighIn) r_z[63:32] <= w_alu_res[63:32];
            r_inport <= '0;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Directed bench for the bus datapath: control micro-steps with hand-computed results.
module tb_datapath;

    logic        Clock = 1'b0;
    logic        Clear;
    logic        PCout, ZHighout, Zlowout, HIout, LOout, InPortout, Cout, MDRout, R2out, R4out;
    logic        MARin, PCin, MDRin, IRin, Yin, IncPC, Read;
    logic [4:0]  AND;
    logic        R5in, R2in, R4in;
    logic [31:0] Mdatain;
    logic        HIin, LOin, ZHighIn, ZLowIn, Cin, branch_flag;
    logic [31:0] BusMuxOut;

    int n_chk  = 0;
    int n_fail = 0;

    datapath dut (
        .Clock(Clock), .Clear(Clear),
        .PCout(PCout), .ZHighout(ZHighout), .Zlowout(Zlowout), .HIout(HIout), .LOout(LOout),
        .InPortout(InPortout), .Cout(Cout), .MDRout(MDRout), .R2out(R2out), .R4out(R4out),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .IncPC(IncPC), .Read(Read), .AND(AND), .R5in(R5in), .R2in(R2in), .R4in(R4in),
        .Mdatain(Mdatain), .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
        .Cin(Cin), .branch_flag(branch_flag), .BusMuxOut(BusMuxOut)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        {PCout, ZHighout, Zlowout, HIout, LOout, InPortout, Cout, MDRout, R2out, R4out} = '0;
        {MARin, PCin, MDRin, IRin, Yin, IncPC, Read} = '0;
        {R5in, R2in, R4in, HIin, LOin, ZHighIn, ZLowIn, Cin, branch_flag} = '0;
        AND = 5'b00000;
    endtask

    // Apply the controls already driven for one clock, then sample 1 time unit after the edge.
    task automatic step();
        @(posedge Clock);
        #1;
        idle();
    endtask

    task automatic mdr_load(input logic [31:0] v);
        Mdatain = v; Read = 1; MDRin = 1;
        step();
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_pc"},  {32'd0, dut.r_pc},  64'd0);
        chk({pfx, "_ir"},  {32'd0, dut.r_ir},  64'd0);
        chk({pfx, "_mar"}, {32'd0, dut.r_mar}, 64'd0);
        chk({pfx, "_mdr"}, {32'd0, dut.r_mdr}, 64'd0);
        chk({pfx, "_y"},   {32'd0, dut.r_y},   64'd0);
        chk({pfx, "_z"},   dut.r_z,            64'd0);
        chk({pfx, "_hi"},  {32'd0, dut.r_hi},  64'd0);
        chk({pfx, "_lo"},  {32'd0, dut.r_lo},  64'd0);
        chk({pfx, "_c"},   {32'd0, dut.r_c},   64'd0);
        chk({pfx, "_r2"},  {32'd0, dut.r_r2},  64'd0);
        chk({pfx, "_r4"},  {32'd0, dut.r_r4},  64'd0);
        chk({pfx, "_r5"},  {32'd0, dut.r_r5},  64'd0);
        chk({pfx, "_bus"}, {32'd0, BusMuxOut}, 64'd0);
    endtask

    initial begin
        idle();
        Mdatain = '0;
        Clear   = 1'b0;
        #12;
        check_all_zero("rst");
        @(negedge Clock);
        Clear = 1'b1;

        // GPR loads through MDR
        mdr_load(32'h22);
        chk("mdr_22", {32'd0, dut.r_mdr}, 64'h22);
        MDRout = 1; R2in = 1; #1;
        chk("bus_mdr", {32'd0, BusMuxOut}, 64'h22);
        step();
        chk("r2", {32'd0, dut.r_r2}, 64'h22);
        mdr_load(32'h24);
        MDRout = 1; R4in = 1; step();
        chk("r4", {32'd0, dut.r_r4}, 64'h24);
        mdr_load(32'h26);
        MDRout = 1; R5in = 1; step();
        chk("r5", {32'd0, dut.r_r5}, 64'h26);

        // Fetch
        PCout = 1; MARin = 1; IncPC = 1; ZLowIn = 1; step();
        chk("t0_mar", {32'd0, dut.r_mar}, 64'h0);
        chk("t0_zlo", {32'd0, dut.r_z[31:0]}, 64'h1);
        Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h4A92_0000; step();
        chk("t1_pc", {32'd0, dut.r_pc}, 64'h1);
        chk("t1_mdr", {32'd0, dut.r_mdr}, 64'h4A92_0000);
        MDRout = 1; IRin = 1; step();
        chk("t2_ir", {32'd0, dut.r_ir}, 64'h4A92_0000);

        // AND R5 <- R2 & R4
        R2out = 1; Yin = 1; step();
        chk("t3_y", {32'd0, dut.r_y}, 64'h22);
        R4out = 1; AND = 5'b01001; ZLowIn = 1; step();
        chk("t4_zlo", {32'd0, dut.r_z[31:0]}, 64'h20);
        Zlowout = 1; R5in = 1; step();
        chk("t5_r5", {32'd0, dut.r_r5}, 64'h20);

        // MUL -2 * 3
        mdr_load(32'hFFFF_FFFE);
        MDRout = 1; Yin = 1; step();
        mdr_load(32'h3);
        MDRout = 1; AND = 5'b01111; ZHighIn = 1; ZLowIn = 1; step();
        chk("mul_z", dut.r_z, 64'hFFFF_FFFF_FFFF_FFFA);
        Zlowout = 1; ZHighout = 1; LOin = 1; #1;
        chk("bus_prio", {32'd0, BusMuxOut}, 64'hFFFF_FFFA);
        step();
        chk("lo", {32'd0, dut.r_lo}, 64'hFFFF_FFFA);
        ZHighout = 1; HIin = 1; step();
        chk("hi", {32'd0, dut.r_hi}, 64'hFFFF_FFFF);

        // DIV 7 / 2, then ADD into low half only
        mdr_load(32'h7);
        MDRout = 1; Yin = 1; step();
        mdr_load(32'h2);
        MDRout = 1; AND = 5'b10000; ZHighIn = 1; ZLowIn = 1; step();
        chk("div_z", dut.r_z, 64'h0000_0001_0000_0003);
        MDRout = 1; AND = 5'b00011; ZLowIn = 1; step();
        chk("add_zlo_only", dut.r_z, 64'h0000_0001_0000_0009);

        // DIV by zero: no bus source, so B = 0
        AND = 5'b10000; ZHighIn = 1; ZLowIn = 1; #1;
        chk("bus_idle", {32'd0, BusMuxOut}, 64'h0);
        step();
        chk("div0_z", dut.r_z, 64'h0);

        // Branch increment with C = -1
        mdr_load(32'h0007_FFFF);
        MDRout = 1; IRin = 1; step();
        Cin = 1; step();
        chk("c_sext", {32'd0, dut.r_c}, 64'hFFFF_FFFF);
        mdr_load(32'h5);
        MDRout = 1; PCin = 1; step();
        PCout = 1; PCin = 1; step();
        chk("pc_self", {32'd0, dut.r_pc}, 64'h5);
        PCout = 1; IncPC = 1; branch_flag = 1; ZHighIn = 1; ZLowIn = 1; AND = 5'b01111; step();
        chk("branch_z", dut.r_z, 64'h4);

        // Asynchronous clear mid-operation; controls ignored while low
        Mdatain = 32'hDEAD_BEEF; Read = 1; MDRin = 1; PCout = 1; PCin = 1;
        #2 Clear = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge Clock); #1;
        chk("rst_hold_mdr", {32'd0, dut.r_mdr}, 64'h0);
        @(negedge Clock);
        Clear = 1'b1;
        @(posedge Clock); #1;
        chk("post_rst_mdr", {32'd0, dut.r_mdr}, 64'hDEAD_BEEF);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
